// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        MULDIV_CTRL_MUL    = 4'd0,
        MULDIV_CTRL_MULH   = 4'd1,
        MULDIV_CTRL_MULHSU = 4'd2,
        MULDIV_CTRL_MULHU  = 4'd3,
        MULDIV_CTRL_DIV    = 4'd4,
        MULDIV_CTRL_DIVU   = 4'd5,
        MULDIV_CTRL_REM    = 4'd6,
        MULDIV_CTRL_REMU   = 4'd7
    } muldiv_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    localparam int unsigned ITER_COUNT    = 32;
    localparam word_t       DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam word_t       INT_MIN       = 32'h8000_0000;

    function automatic word_t abs_w(input word_t v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step
    import muldiv_pkg::*;
(
    input  word_t rem_in,
    input  word_t divisor,
    input  logic  dividend_bit,
    output word_t rem_out,
    output logic  q_bit
);

    logic [32:0] trial;
    logic [32:0] diff;

    // rem_in < divisor always holds, so a borrow shows up as diff[32].
    always_comb begin
        trial   = {rem_in, dividend_bit};
        diff    = trial - {1'b0, divisor};
        q_bit   = ~diff[32];
        rem_out = q_bit ? diff[31:0] : trial[31:0];
    end

endmodule

// File: rtl/muldiv.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready on both sides.
// MULDIV_DSP_MUL_EN: multiplies become a single-cycle 33x33 signed multiply.
module muldiv
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  muldiv_ctrl_t      ctrl,
    input  logic [1:0][31:0]  in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       out,
    output logic              out_valid,
    input  logic              out_ready
);

    muldiv_state_t state, state_nxt;
    muldiv_ctrl_t  op;
    logic [5:0]    cnt;
    word_t         acc_hi, acc_lo, opb;
    logic          neg;
    word_t         res;

    word_t  a, b, a_mag, b_mag, special_res, fix_res;
    logic   is_mul_in, is_div_in, special, neg_in, op_is_mul;
    word_t  step_rem;
    logic   step_q;

    always_comb begin
        a = in[0];
        b = in[1];
    end

    // ---------------- request decode ----------------
`ifdef MULDIV_DSP_MUL_EN
    logic signed [32:0] dsp_a, dsp_b;
    logic signed [65:0] dsp_p;
    word_t              dsp_res;

    always_comb begin
        dsp_a   = {(ctrl == MULDIV_CTRL_MULH || ctrl == MULDIV_CTRL_MULHSU) & a[31], a};
        dsp_b   = {(ctrl == MULDIV_CTRL_MULH) & b[31], b};
        dsp_p   = dsp_a * dsp_b;
        dsp_res = (ctrl == MULDIV_CTRL_MUL) ? dsp_p[31:0] : dsp_p[63:32];
    end
`endif

    always_comb begin
        is_mul_in   = ctrl inside {MULDIV_CTRL_MUL, MULDIV_CTRL_MULH,
                                   MULDIV_CTRL_MULHSU, MULDIV_CTRL_MULHU};
        is_div_in   = ctrl inside {MULDIV_CTRL_DIV, MULDIV_CTRL_DIVU,
                                   MULDIV_CTRL_REM, MULDIV_CTRL_REMU};
        a_mag       = a;
        b_mag       = b;
        neg_in      = 1'b0;
        special     = 1'b0;
        special_res = '0;
        case (ctrl)
            MULDIV_CTRL_MULH,
            MULDIV_CTRL_DIV: begin
                a_mag  = abs_w(a);
                b_mag  = abs_w(b);
                neg_in = a[31] ^ b[31];
            end
            MULDIV_CTRL_MULHSU: begin
                a_mag  = abs_w(a);
                neg_in = a[31];
            end
            MULDIV_CTRL_REM: begin
                a_mag  = abs_w(a);
                b_mag  = abs_w(b);
                neg_in = a[31];
            end
            default: ;
        endcase
        if (!is_mul_in && !is_div_in) begin
            special = 1'b1;
        end else if (is_div_in && b == '0) begin
            special     = 1'b1;
            special_res = (ctrl == MULDIV_CTRL_DIV || ctrl == MULDIV_CTRL_DIVU)
                          ? DIV_BY_ZERO_Q : a;
        end else if ((ctrl == MULDIV_CTRL_DIV || ctrl == MULDIV_CTRL_REM)
                     && a == INT_MIN && b == '1) begin
            special     = 1'b1;
            special_res = (ctrl == MULDIV_CTRL_DIV) ? INT_MIN : '0;
        end
`ifdef MULDIV_DSP_MUL_EN
        else if (is_mul_in) begin
            special     = 1'b1;
            special_res = dsp_res;
        end
`endif
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = special ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        out       = res;
    end

    // ---------------- datapath ----------------
    // acc_hi/acc_lo hold {product hi, multiplier/product lo} for multiplies and
    // {partial remainder, dividend/quotient shift register} for divides.
    assign op_is_mul = op inside {MULDIV_CTRL_MUL, MULDIV_CTRL_MULH,
                                  MULDIV_CTRL_MULHSU, MULDIV_CTRL_MULHU};

    div_step u_div_step (
        .rem_in       (acc_hi),
        .divisor      (opb),
        .dividend_bit (acc_lo[31]),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

`ifndef MULDIV_DSP_MUL_EN
    logic [32:0] mul_sum;
    logic [63:0] prod;

    always_comb begin
        mul_sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opb}) : {1'b0, acc_hi};
        prod    = neg ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
    end
`endif

    always_comb begin
        fix_res = '0;
        case (op)
`ifndef MULDIV_DSP_MUL_EN
            MULDIV_CTRL_MUL:    fix_res = prod[31:0];
            MULDIV_CTRL_MULH,
            MULDIV_CTRL_MULHSU,
            MULDIV_CTRL_MULHU:  fix_res = prod[63:32];
`endif
            MULDIV_CTRL_DIV,
            MULDIV_CTRL_DIVU:   fix_res = neg ? (~acc_lo + 32'd1) : acc_lo;
            MULDIV_CTRL_REM,
            MULDIV_CTRL_REMU:   fix_res = neg ? (~acc_hi + 32'd1) : acc_hi;
            default:            fix_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op     <= MULDIV_CTRL_MUL;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            neg    <= 1'b0;
            res    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    op  <= ctrl;
                    neg <= neg_in;
                    cnt <= 6'(ITER_COUNT);
                    if (special) begin
                        res <= special_res;
                    end else begin
                        acc_hi <= '0;
                        opb    <= is_mul_in ? a_mag : b_mag;
                        acc_lo <= is_mul_in ? b_mag : a_mag;
                    end
                end
                ST_CALC: if (cnt != '0) begin
                    cnt <= cnt - 6'd1;
`ifndef MULDIV_DSP_MUL_EN
                    if (op_is_mul) begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
                    end else
`endif
                    begin
                        acc_hi <= step_rem;
                        acc_lo <= {acc_lo[30:0], step_q};
                    end
                end
                ST_FIX:  res <= fix_res;
                default: ;
            endcase
        end
    end

`ifdef MULDIV_DSP_MUL_EN
    logic unused_ok;
    assign unused_ok = op_is_mul ^ dsp_p[65] ^ dsp_p[64];
`endif

endmodule

// File: tb/tb_muldiv.sv
// Randomized and directed checks of muldiv against a plain-arithmetic RV32M model.
module tb_muldiv;
    import muldiv_pkg::*;

    logic             clk;
    logic             rst_n;
    muldiv_ctrl_t     ctrl;
    logic [1:0][31:0] op_in;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      out;
    logic             out_valid;
    logic             out_ready;

    int total = 0;
    int bad   = 0;

    muldiv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl      (ctrl),
        .in        (op_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // RV32M semantics written straight from the ISA rules using 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input muldiv_ctrl_t c, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (c)
            MULDIV_CTRL_MUL:    begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            MULDIV_CTRL_MULH:   begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
            MULDIV_CTRL_MULHSU: begin sp = longint'(sa) * longint'({32'd0, b}); return sp[63:32]; end
            MULDIV_CTRL_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            MULDIV_CTRL_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            MULDIV_CTRL_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            MULDIV_CTRL_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MULDIV_CTRL_REMU: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Edges after the accept edge before out_valid is seen: 0 means the result
    // is visible in the cycle right after acceptance (single-cycle path).
    function automatic int ref_latency(input muldiv_ctrl_t c, input logic [31:0] a,
                                       input logic [31:0] b);
        logic is_div, ovf;
        is_div = (c >= MULDIV_CTRL_DIV) && (c <= MULDIV_CTRL_REMU);
        ovf    = (c == MULDIV_CTRL_DIV || c == MULDIV_CTRL_REM)
                 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        if (c > MULDIV_CTRL_REMU) return 0;
        if (is_div && (b == 0 || ovf)) return 0;
`ifdef MULDIV_DSP_MUL_EN
        if (!is_div) return 0;
`endif
        return 34;
    endfunction

    task automatic run_op(input muldiv_ctrl_t c, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] exp;
        int          lat;
        exp = ref_result(c, a, b);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        ctrl     = c;
        op_in[0] = a;
        op_in[1] = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency op%0d", c), 32'(lat), 32'(ref_latency(c, a, b)));
        check($sformatf("result op%0d %08h %08h", c, a, b), out, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_out", out, exp);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("in_ready_after_take", 32'(in_ready), 32'd1);
        check("out_valid_after_take", 32'(out_valid), 32'd0);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 3));
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        ctrl      = MULDIV_CTRL_MUL;
        op_in     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out", out, 32'd0);
        rst_n = 1'b1;

        run_op(MULDIV_CTRL_MUL,    32'd7,          32'd6,          0);
        run_op(MULDIV_CTRL_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
        run_op(MULDIV_CTRL_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
        run_op(MULDIV_CTRL_MULHSU, 32'hFFFF_FFFF,  32'd2,          0);
        run_op(MULDIV_CTRL_DIV,    32'hFFFF_FFF9,  32'd2,          0);
        run_op(MULDIV_CTRL_REM,    32'hFFFF_FFF9,  32'd2,          0);
        run_op(MULDIV_CTRL_DIVU,   32'd100,        32'd7,          0);
        run_op(MULDIV_CTRL_DIV,    32'd5,          32'd0,          0);
        run_op(MULDIV_CTRL_REM,    32'd5,          32'd0,          0);
        run_op(MULDIV_CTRL_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  0);
        run_op(MULDIV_CTRL_REM,    32'h8000_0000,  32'hFFFF_FFFF,  0);
        run_op(muldiv_ctrl_t'(4'd9), 32'd3,        32'd4,          0);
        run_op(MULDIV_CTRL_REMU,   32'd100,        32'd7,          10);

        // Abort a divide in the middle of its iterations.
        @(negedge clk);
        ctrl     = MULDIV_CTRL_DIVU;
        op_in[0] = 32'd1000;
        op_in[1] = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("midop_busy", 32'(in_ready), 32'd0);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out", out, 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        run_op(MULDIV_CTRL_DIVU, 32'd9, 32'd3, 0);

        for (int n = 0; n < 60; n++) begin
            run_op(muldiv_ctrl_t'(4'($urandom_range(0, 8))), rand_word(), rand_word(),
                   $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
